// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcodes, FSM states and signed-overflow helper shared by alu_pipe
package alu_pipe_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic {IDLE, MUL} state_t;

  function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add unsigned multiplier, one bit per cycle, first bit folded into start
module alu_mul_seq
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0] count;

  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] x, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, x[2*WIDTH-1:WIDTH]} + {1'b0, m & {WIDTH{x[0]}}};
    return {s, x[WIDTH-1:1]};
  endfunction

  assign done = count == CW'(WIDTH);
  assign product = acc;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      mcand <= '0;
      count <= '0;
    end else if (start) begin
      acc <= step({{WIDTH{1'b0}}, b}, a);
      mcand <= a;
      count <= CW'(1);
    end else if (done) begin
      count <= '0;
    end else if (count != '0) begin
      acc <= step(acc, mcand);
      count <= count + CW'(1);
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with registered result/flags and optional iterative multiply
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);
  localparam int SW = $clog2(WIDTH);
  state_t state, state_nx;
  logic live, accept, is_mul, load, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0] add_s, sub_s;
  logic [WIDTH-1:0] alu_res, res_nx;
  logic [SW-1:0] shamt;
  logic alu_carry, alu_ovf;

  assign shamt = b[SW-1:0];
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign is_mul = (MUL_EN != 0) && control == OP_MUL;
  // live holds in_ready low until the first edge after reset release
  assign in_ready = live && state == IDLE && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;

  assign alu_res = control == OP_AND ? a & b :
                   control == OP_OR  ? a | b :
                   control == OP_XOR ? a ^ b :
                   control == OP_ADD ? add_s[WIDTH-1:0] :
                   control == OP_SUB ? sub_s[WIDTH-1:0] :
                   control == OP_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
                   control == OP_SLL ? a << shamt :
                   control == OP_SRL ? a >> shamt : '0;
  assign alu_carry = control == OP_ADD ? add_s[WIDTH] :
                     control == OP_SUB ? sub_s[WIDTH] : 1'b0;
  assign alu_ovf = control == OP_ADD ? signed_ovf(a[WIDTH-1], b[WIDTH-1], add_s[WIDTH-1]) :
                   control == OP_SUB ? signed_ovf(a[WIDTH-1], ~b[WIDTH-1], sub_s[WIDTH-1]) : 1'b0;
  assign res_nx = state == MUL ? mul_prod[WIDTH-1:0] : alu_res;

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk(clk),
        .rst_n(rst_n),
        .start(accept && is_mul),
        .a(a),
        .b(b),
        .done(mul_done),
        .product(mul_prod)
      );
    end else begin : g_nomul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_comb begin
    state_nx = state;
    load = 1'b0;
    if (state == IDLE) begin
      load = accept && !is_mul;
      state_nx = accept && is_mul ? MUL : IDLE;
    end else if (mul_done) begin
      load = 1'b1;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      live <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      zero <= 1'b0;
      carry <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        result <= res_nx;
        zero <= res_nx == '0;
        negative <= res_nx[WIDTH-1];
        carry <= state == IDLE && alu_carry;
        overflow <= state == MUL ? |mul_prod[2*WIDTH-1:WIDTH] : alu_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized scoreboard bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;
  localparam int W = 8;
  typedef struct {logic [W-1:0] r; logic z, c, v, n;} exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready, nm_in_valid, nm_out_ready;
  logic [W-1:0] a, b;
  logic [3:0] control;
  logic in_ready, out_valid, zero, carry, overflow, negative;
  logic [W-1:0] result;
  logic nm_in_ready, nm_out_valid, nm_zero, nm_carry, nm_overflow, nm_negative;
  logic [W-1:0] nm_result;
  exp_t exp_q[$];
  int total = 0, bad = 0;
  logic held = 1'b0;
  logic [W-1:0] held_r;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow), .negative(negative)
  );

  alu_pipe #(.WIDTH(W), .MUL_EN(0)) u_nm (
    .clk(clk), .rst_n(rst_n), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .a(a), .b(b), .control(control), .out_valid(nm_out_valid), .out_ready(nm_out_ready),
    .result(nm_result), .zero(nm_zero), .carry(nm_carry), .overflow(nm_overflow), .negative(nm_negative)
  );

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int ua = x, ub = y, sa = $signed(x), sb = $signed(y), f = 0;
    exp_t e;
    e = '{r: '0, z: 1'b0, c: 1'b0, v: 1'b0, n: 1'b0};
    case (op)
      4'd0: f = ua & ub;
      4'd1: f = ua | ub;
      4'd3: f = ua ^ ub;
      4'd2: begin f = ua + ub; e.c = f > 255; e.v = (sa + sb > 127) || (sa + sb < -128); end
      4'd6: begin f = ua - ub; e.c = ua >= ub; e.v = (sa - sb > 127) || (sa - sb < -128); end
      4'd7: f = (sa < sb) ? 1 : 0;
      4'd4: f = ua << (ub % W);
      4'd5: f = ua >> (ub % W);
      4'd8: begin f = ua * ub; e.v = f > 255; end
      default: f = 0;
    endcase
    e.r = f[W-1:0];
    e.z = e.r == 0;
    e.n = e.r[W-1];
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, output int waits);
    logic rdy;
    #1;
    in_valid = 1'b1;
    control = op;
    a = x;
    b = y;
    waits = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      waits++;
      if (rdy) begin
        exp_q.push_back(model(op, x, y));
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: op %0h not accepted in 200 cycles", op);
    in_valid = 1'b0;
  endtask

  task automatic go(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int w;
    send(op, x, y, w);
  endtask

  task automatic drop();
    #1 in_valid = 1'b0;
  endtask

  task automatic mul_latency(input logic [W-1:0] x, input logic [W-1:0] y);
    int k;
    go(4'd8, x, y);
    drop();
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
      chk("mul_in_ready_low", in_ready, 0);
    end
    chk("mul_latency", k, W);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (held && rst_n) begin
      total++;
      if (!out_valid || result !== held_r) begin
        bad++;
        $display("FAIL hold: out_valid=%b result=%h required 1/%h", out_valid, result, held_r);
      end
    end
    held = rst_n && out_valid && !out_ready;
    held_r = result;
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: result=%h with nothing expected", result);
      end else begin
        e = exp_q.pop_front();
        if ({result, zero, carry, overflow, negative} !== {e.r, e.z, e.c, e.v, e.n}) begin
          bad++;
          $display("FAIL result: got r=%h z%b c%b v%b n%b required r=%h z%b c%b v%b n%b",
                   result, zero, carry, overflow, negative, e.r, e.z, e.c, e.v, e.n);
        end
      end
    end
  end

  initial begin
    int w[4];
    logic rnd_done;
    logic [W-1:0] corner[6];
    corner[0] = 8'h00; corner[1] = 8'hFF; corner[2] = 8'h7F;
    corner[3] = 8'h80; corner[4] = 8'h01; corner[5] = 8'h0C;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; nm_in_valid = 1'b0; nm_out_ready = 1'b1;
    a = '0; b = '0; control = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, carry, overflow, negative}, 0);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1 chk("in_ready_after_edge", in_ready, 1);

    go(4'd2, 8'h7F, 8'h01);
    #1;
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 8'h80);
    chk("add_flags_zcvn", {zero, carry, overflow, negative}, 4'b0011);
    go(4'd6, 8'h05, 8'h05);
    go(4'd6, 8'h00, 8'h01);
    drop();
    mul_latency(8'h10, 8'h10);
    mul_latency(8'h0D, 8'h0B);

    fork
      begin
        for (int i = 0; i < 4; i++) send(4'd1, 8'h11 << i, 8'h80 >> i, w[i]);
      end
      begin
        #1 out_ready = 1'b0;
        repeat (2) begin
          @(posedge clk);
          #1 chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drop();
    chk("stream_or3_waits", w[2], 1);
    chk("stream_or4_waits", w[3], 1);

    go(4'd8, 8'h33, 8'h05);
    drop();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midmul_rst_out_valid", out_valid, 0);
    chk("midmul_rst_in_ready", in_ready, 0);
    chk("midmul_rst_result", result, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1 chk("no_stale_out_valid", out_valid, 0);
    end
    go(4'd0, 8'hF0, 8'h3C);
    go(4'd7, 8'h80, 8'h01);
    go(4'd5, 8'hF0, 8'h0C);
    go(4'd4, 8'h81, 8'h09);
    go(4'hF, 8'h55, 8'hAA);
    drop();
    repeat (3) @(posedge clk);

    #1;
    control = 4'd8; a = 8'h0D; b = 8'h0B; nm_in_valid = 1'b1;
    @(posedge clk);
    #1 nm_in_valid = 1'b0;
    chk("nomul_valid", nm_out_valid, 1);
    chk("nomul_result", nm_result, 0);
    chk("nomul_flags_zcvn", {nm_zero, nm_carry, nm_overflow, nm_negative}, 4'b1000);

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [W-1:0] x, y;
          x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
          y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
          go(4'($urandom_range(0, 15)), x, y);
          if ($urandom_range(0, 4) == 0) begin
            drop();
            @(posedge clk);
          end
        end
        drop();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the team's 8-bit ALU.
- Operands and opcode are accepted on a valid/ready input channel. Results and flags are returned on a registered valid/ready output channel.
- Adds XOR, SUB, SLT, shifts and an iterative multi-cycle multiply.
- Corrects flag semantics: zero is active when the result is 0, and overflow is signed.
- Sits between the operand register file and the writeback stage of the datapath.

Parameters:
WIDTH, 8, operand/result width; power of two, 4..64
MUL_EN, 1, 1 = MUL implemented; 0 = MUL opcode treated as invalid

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B (shift amount = b[$clog2(WIDTH)-1:0])
control  input  4  opcode
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  result
zero  output  1  result == 0
carry  output  1  adder carry-out
overflow  output  1  signed overflow (ADD/SUB), high-half nonzero (MUL)
negative  output  1  result[WIDTH-1]

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: in_ready=0 while rst_n is low, then 1 from the first clk edge after release. out_valid, result, zero, carry, overflow and negative are all 0. FSM enters IDLE; multiply counter is cleared.
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (a + ~b + 1)
  - 0011 XOR
  - 0111 SLT (signed a<b ? 1 : 0)
  - 0100 SLL
  - 0101 SRL (logical)
  - 1000 MUL (low WIDTH bits of unsigned a*b)
  - All others invalid: result=0, zero=1, carry=0, overflow=0, negative=0.
- Flags:
  - carry: valid for ADD/SUB only, otherwise 0. For SUB, carry=1 means no borrow.
  - overflow (ADD/SUB): signed overflow, i.e. operand sign bits equal and result sign different.
  - overflow (MUL): upper WIDTH bits of the full product are nonzero.
  - overflow for all other ops: 0.
  - zero and negative are derived from the registered result for every op.
- Handshake:
  - Accept occurs on a clk edge with in_valid & in_ready.
  - Output transfer occurs on a clk edge with out_valid & out_ready.
  - result and all flags are held stable while out_valid=1 and out_ready=0.
- FSM states:
  - IDLE: in_ready = !out_valid | out_ready.
    - Accept of a single-cycle op: result registered at the same edge; out_valid=1 next cycle (latency 1).
    - Simultaneous output transfer and new accept is allowed, giving throughput 1 op/cycle.
    - Accept of MUL (MUL_EN=1) → MUL.
  - MUL: in_ready=0. Shift-add one bit per cycle. After WIDTH iterations, load result/flags, set out_valid=1, → IDLE.
    - out_valid rises exactly WIDTH cycles after the accept edge.
  - Output slot occupied in IDLE: in_ready follows the IDLE rule above. A MUL is not accepted unless the slot frees on the same edge.
- Shifts: amount is masked to the low $clog2(WIDTH) bits of b; no saturation.
- Reset mid-MUL: aborts immediately. The partial product is discarded and no result is produced.
- in_valid deasserted without acceptance: no state change.

Decomposition:
- Package alu_pipe_pkg holds:
  - opcode localparams (OP_AND … OP_MUL)
  - FSM state enum (IDLE, MUL)
  - helper function for the signed-overflow equation
- Sub-module alu_mul_seq: iterative unsigned multiplier with start/done.
  - Internal registers: 2*WIDTH accumulator and $clog2(WIDTH)+1 counter.
  - Instantiated only when MUL_EN=1, via generate.
- Single-cycle datapath stays in alu_pipe.

Test Plan:
1. ADD a=0x7F b=0x01, out_ready=1 → next cycle out_valid=1, result=0x80, overflow=1, negative=1, carry=0, zero=0.
2. SUB 0x05-0x05 → result=0x00, zero=1, carry=1. Then SUB 0x00-0x01 → 0xFF, carry=0, negative=1, overflow=0.
3. MUL a=0x10 b=0x10 → in_ready=0 for 8 cycles, out_valid at accept+8, result=0x00, zero=1, overflow=1. Then MUL 0x0D*0x0B → 0x8F, overflow=0.
4. Stream 4 back-to-back ORs, holding out_ready=0 for 3 cycles after the first → result held stable, in_ready=0 while blocked, all 4 results delivered in order with no loss. Throughput 1/cycle once out_ready=1.
5. Assert rst_n low 4 cycles into a MUL → all outputs 0 immediately, no stale out_valid after release. A following AND 0xF0&0x3C returns 0x30.
6. SLT 0x80,0x01 → 0x01. SRL 0xF0 by b=0x0C (masked to 4) → 0x0F. Opcode 1111 → result 0, zero=1. MUL with MUL_EN=0 → invalid-op response at latency 1.
